// File: rtl/des_pkg.sv
// des_pkg: shared block width and FSM state encoding for the DES CBC chainer
package des_pkg;
  localparam int DES_BLK_W = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_e;
endpackage

// File: rtl/des_cbc_chain.sv
// des_cbc_chain: CBC/ECB chaining wrapper around an external DES round engine, one block in flight
module des_cbc_chain
  import des_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk1,
  input  logic                 reset_n,
  input  logic                 mode_cbc,
  input  logic                 decrypt,
  input  logic [DES_BLK_W-1:0] iv,
  input  logic                 iv_load,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DES_BLK_W-1:0] in_data,
  output logic                 core_start,
  output logic [DES_BLK_W-1:0] core_in,
  input  logic                 core_done,
  input  logic [DES_BLK_W-1:0] core_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DES_BLK_W-1:0] out_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     block_count
);
  state_e               state_q, state_d;
  logic [DES_BLK_W-1:0] chain_q, chain_d, blk_q, blk_d, core_in_q, core_in_d, out_q, out_d;
  logic                 cbc_q, cbc_d, dec_q, dec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept, done_w, iv_w;
  assign accept = in_valid && in_ready;
  assign done_w = (state_q == WAIT) && core_done;
  assign iv_w   = (state_q == IDLE) && iv_load;
  // state register
  always_ff @(posedge clk1 or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  // next-state logic; core_done outside WAIT never moves the FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = core_done ? EMIT : WAIT;
      EMIT:    state_d = out_ready ? IDLE : EMIT;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state; in_ready also drops while iv is being loaded
  always_comb begin
    in_ready   = (state_q == IDLE) && !iv_load && reset_n;
    core_start = state_q == ISSUE;
    out_valid  = state_q == EMIT;
    busy       = state_q != IDLE;
  end
  // datapath next state: capture on accept, chain/result update on core_done
  always_comb begin
    blk_d     = accept ? in_data : blk_q;
    cbc_d     = accept ? mode_cbc : cbc_q;
    dec_d     = accept ? decrypt : dec_q;
    core_in_d = accept ? ((mode_cbc && !decrypt) ? in_data ^ chain_q : in_data) : core_in_q;
    out_d     = done_w ? ((cbc_q && dec_q) ? core_out ^ chain_q : core_out) : out_q;
    chain_d   = iv_w ? iv : (done_w && cbc_q) ? (dec_q ? blk_q : core_out) : chain_q;
    cnt_d     = cnt_q + CNT_W'(out_valid && out_ready);
  end
  // datapath registers
  always_ff @(posedge clk1 or negedge reset_n)
    if (!reset_n) begin
      chain_q   <= '0;
      blk_q     <= '0;
      core_in_q <= '0;
      out_q     <= '0;
      cbc_q     <= 1'b0;
      dec_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      chain_q   <= chain_d;
      blk_q     <= blk_d;
      core_in_q <= core_in_d;
      out_q     <= out_d;
      cbc_q     <= cbc_d;
      dec_q     <= dec_d;
      cnt_q     <= cnt_d;
    end
  assign core_in     = core_in_q;
  assign out_data    = out_q;
  assign block_count = cnt_q;
endmodule

// File: doc/des_cbc_chain.md
DES_CBC_CHAIN -- requirements
Module: des_cbc_chain

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the processed-block counter.
REQ-002 The block SHALL have these ports:
  - clk1  in  1  sole clock, rising edge
  - reset_n  in  1  asynchronous, active-low reset
  - mode_cbc  in  1  1 = CBC chaining, 0 = ECB pass-through
  - decrypt  in  1  1 = decrypt, 0 = encrypt
  - iv  in  64  initialisation vector
  - iv_load  in  1  single-cycle pulse that loads iv into the chain register
  - in_valid  in  1  upstream block valid (pipe-in FIFO side)
  - in_ready  out  1  block accepts in_data this cycle
  - in_data  in  64  plaintext or ciphertext block
  - core_start  out  1  single-cycle start pulse to the DES round engine
  - core_in  out  64  block presented to the DES round engine
  - core_done  in  1  DES round engine result valid, single cycle
  - core_out  in  64  DES round engine result
  - out_valid  out  1  result block valid (pipe-out side)
  - out_ready  in  1  downstream accepts out_data
  - out_data  out  64  chained result block
  - busy  out  1  high in any state other than IDLE
  - block_count  out  CNT_W  blocks emitted since reset

Function
REQ-003 The FSM SHALL have exactly four states, IDLE, ISSUE, WAIT and EMIT, with these transitions:
  - IDLE -> ISSUE on accept
  - ISSUE -> WAIT unconditionally
  - WAIT -> EMIT on core_done
  - EMIT -> IDLE on out_valid && out_ready
REQ-004 in_ready SHALL be (state==IDLE) && !iv_load && reset_n, and an accept SHALL be in_valid && in_ready.
REQ-005 On accept, the block SHALL register in_data into blk_reg and register mode_cbc and decrypt; these registered copies govern the whole block.
REQ-006 On accept, core_in SHALL be registered as in_data^chain when encrypting in CBC mode, and as in_data otherwise.
REQ-007 core_start SHALL be high for exactly the one cycle spent in ISSUE, i.e. one cycle after accept.
REQ-008 core_in SHALL be held stable from ISSUE until the block leaves WAIT.
REQ-009 core_done in any state other than WAIT SHALL be ignored.
REQ-010 On core_done in WAIT, out_data and chain SHALL be registered as follows:
  - CBC encrypt: out_data = core_out; chain = core_out
  - CBC decrypt: out_data = core_out^chain; chain = blk_reg
  - ECB: out_data = core_out; chain unchanged
REQ-011 out_valid SHALL be high exactly while in EMIT.
REQ-012 out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-013 block_count SHALL increment by 1 on each out_valid && out_ready and wrap from 2^CNT_W-1 to 0.
REQ-014 iv_load SHALL load chain from iv only in IDLE, and SHALL be ignored in all other states.
REQ-015 iv_load and in_valid asserted together in IDLE SHALL load iv and accept no block that cycle.
REQ-016 Latency SHALL be one cycle from accept to core_start, and one cycle from core_done to out_valid.
REQ-017 Throughput SHALL be at most one block in flight.

Reset
REQ-018 While reset_n is low, the block SHALL asynchronously force:
  - state = IDLE
  - chain = 0, blk_reg = 0
  - core_in = 0, out_data = 0
  - core_start = 0, out_valid = 0, busy = 0, in_ready = 0
  - block_count = 0
REQ-019 Reset asserted mid-block SHALL abandon the block without emitting it, and a core_done arriving after reset release SHALL be ignored.

Structure
REQ-020 Package des_pkg SHALL hold the state enumeration and the constant DES_BLK_W = 64.
REQ-021 The block SHALL be flat, with no sub-module, because the XOR/select datapath is too small to justify one.

Verification
Stub core: core_done fires 16 cycles after core_start.
REQ-022 ECB bench: mode_cbc=0, in_data=0x0123456789ABCDEF, stub returns 0xFEDCBA9876543210 -> core_in=0x0123456789ABCDEF, out_data=0xFEDCBA9876543210, block_count=1.
REQ-023 CBC encrypt bench: iv=0x1111111111111111, blocks 0x2222222222222222 then 0x0000000000000000, stub returns 0xAAAAAAAAAAAAAAAA -> core_in 0x3333333333333333, then 0xAAAAAAAAAAAAAAAA.
REQ-024 CBC decrypt bench: iv=0x1111111111111111, block 0x9999999999999999, stub returns 0x4444444444444444 -> out_data=0x5555555555555555; next block XORs with 0x9999999999999999.
REQ-025 Backpressure bench: out_ready low for 10 cycles in EMIT -> out_valid=1 and out_data stable, in_ready=0 and block_count unchanged throughout; count increments on the release cycle.
REQ-026 Reset bench: reset_n pulsed low in WAIT -> all outputs 0, then a stray core_done -> no out_valid.
REQ-027 Collision bench: iv_load and in_valid high together in IDLE -> in_ready=0 and the block is accepted next cycle using the new iv.
